qsn_shift_sequencer: RTL and testbench
======================================

# qsn_shift_sequencer

Schedules the cyclic shift factors that drive the 85-lane QSN permutation controller during layered decoding. It holds a per-layer circulant shift table loaded at configuration time. On `start` it walks iterations, then layers, then submatrix columns, issuing a forward shift (variable-to-check page) and then the reverse shift (check-to-variable page) for each column over a valid/ready handshake. `sched_cmd` is emitted alongside each shift so the page-alignment stage selects the matching message source.

## Interface
- `CHECK_PARALLELISM`, 85, circulant size P; every shift is in [0, P-1]
- `SHIFT_WIDTH`, 7, width of a shift factor
- `LAYER_NUM`, 4, layers per iteration
- `ROW_WEIGHT`, 6, submatrix columns per layer
- `ITER_WIDTH`, 5, width of the iteration counter
- `ADDR_WIDTH`, 5, table address width; must be ≥ clog2(LAYER_NUM*ROW_WEIGHT)

Ports:
- `sys_clk`  in  1  single clock
- `rstn`  in  1  asynchronous active-low reset
- `cfg_we`  in  1  table write strobe; honoured only in IDLE
- `cfg_addr`  in  ADDR_WIDTH  table entry, computed as layer*ROW_WEIGHT+col
- `cfg_shift`  in  SHIFT_WIDTH  shift value to store
- `start`  in  1  begin decoding; sampled only in IDLE
- `iter_max`  in  ITER_WIDTH  iteration count; captured at start; 0 is treated as 1
- `shift_ready`  in  1  downstream accepts the current shift
- `shift_factor`  out  SHIFT_WIDTH  shift for the QSN controller
- `shift_valid`  out  1  `shift_factor` is valid
- `sched_cmd`  out  1  0 = variable-message phase, 1 = check-message phase
- `layer_idx`  out  clog2(LAYER_NUM)  current layer
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when the last shift is accepted
- `cfg_err`  out  1  sticky configuration error (see Configuration)

## Operation
- The table has LAYER_NUM*ROW_WEIGHT registers and resets to 0. Writes with `cfg_addr` ≥ depth are ignored.
- FSM states: IDLE, VN, CN, DONE.
  - IDLE: on `start`, capture `iter_max`, clear counters (iter=0, layer=0, col=0), go to VN.
  - VN: issue the table entry for (layer, col) with `sched_cmd`=0. Each accepted beat (`shift_valid & shift_ready`) increments col. Acceptance at col=ROW_WEIGHT-1 sets col=0 and moves to CN.
  - CN: issue the reverse shift (P − s) mod P with `sched_cmd`=1; s=0 gives 0. Each accepted beat increments col. Acceptance at col=ROW_WEIGHT-1:
    - layer < LAYER_NUM-1: layer+1, go to VN.
    - layer = LAYER_NUM-1, not last iteration: layer=0, iter+1, go to VN.
    - last iteration: go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- The reverse shift is computed as P − s for s≠0, at SHIFT_WIDTH+1 bits, then truncated. No wrap beyond P.
- Handshake rules:
  - While `shift_valid`=1 and `shift_ready`=0, `shift_factor`, `sched_cmd` and `layer_idx` hold stable.
  - `shift_valid` never drops without acceptance, except on reset.
- `start` while busy and `cfg_we` outside IDLE are ignored; the table does not change during a run.
- Reset mid-run: all state returns to IDLE immediately, outputs go to reset values and the table clears.

## Timing
- Reset values: `shift_factor`=0, `shift_valid`=0, `sched_cmd`=0, `layer_idx`=0, `busy`=0, `done`=0, `cfg_err`=0.
- All outputs are registered.
- `start` high at edge k gives `busy`=1 and `shift_valid`=1 with the first shift after edge k+1.
- With `shift_ready` held high, one shift is issued per cycle with no bubbles, including the VN→CN, CN→VN and layer/iteration boundaries.
- A full run takes iter_max*LAYER_NUM*2*ROW_WEIGHT beats. `done` is asserted the cycle after the final acceptance; `busy` falls the cycle after that.
- A table write at edge k is visible to a `start` at edge k+1.

## Configuration
- `QSN_SEQ_CFG_CHECK_EN`
  - Defined: a write with `cfg_shift` ≥ CHECK_PARALLELISM is dropped (the entry keeps its old value) and `cfg_err` is set. `cfg_err` stays set until reset.
  - Undefined: all in-range-address writes are stored as given, `cfg_err` is tied to 0, and out-of-range shifts produce undefined permutation results.

## Test plan
- Load entry 0 = 5 and entry 1 = 0, all others 10; `start` with `iter_max`=1 and ready held high. Required: the first beats are 5, 0, 10, 10, 10, 10 with `sched_cmd`=0, then 80, 0, 75, 75, 75, 75 with `sched_cmd`=1. Total 48 beats, `done` at beat 48+1.
- Drop `shift_ready` for 3 cycles in the middle of layer 2. Required: outputs are stable while stalled, no beat is lost or duplicated, and `layer_idx` sequence is 0,0,1,1,2,2,3,3 per phase.
- `iter_max`=0 and `iter_max`=3. Required: 48 and 144 beats respectively; `done` is a single pulse.
- `start` and `cfg_we` pulsed during a run. Required: both ignored, and the table reads back the original values on the next run.
- Assert `rstn` low at beat 20. Required: outputs return to their reset values asynchronously, and a new run after reset emits all-zero shifts.
- With the macro defined, write 85 to entry 3. Required: `cfg_err`=1 and entry 3 unchanged. Without the macro, entry 3 holds 85 and `cfg_err`=0.

Source files
------------

// File: rtl/qsn_shift_sequencer.sv
// qsn_shift_sequencer
//   Issues the cyclic shift factors for the QSN permutation controller during layered
//   decoding. For every iteration and layer it walks the submatrix columns twice: first
//   the stored shift (variable-to-check page, sched_cmd=0), then the reverse shift
//   (P - s) mod P (check-to-variable page, sched_cmd=1), over a valid/ready handshake.
//
// Ports
//   sys_clk, rstn       clock, asynchronous active-low reset
//   cfg_we/addr/shift   shift table write port (IDLE only), addr = layer*ROW_WEIGHT+col
//   start, iter_max     begin a run; iter_max captured at start, 0 treated as 1
//   shift_ready         downstream accepts the current beat
//   shift_factor/valid  registered beat for the QSN controller
//   sched_cmd           0 = variable-message phase, 1 = check-message phase
//   layer_idx           layer of the current beat
//   busy, done          run in progress / one-cycle pulse after the last acceptance
//   cfg_err             sticky out-of-range shift write flag
//
// Build option
//   QSN_SEQ_CFG_CHECK_EN: reject table writes with shift >= CHECK_PARALLELISM and set
//   cfg_err. Without it every in-range-address write is stored and cfg_err is 0.

module qsn_shift_sequencer #(
   parameter int unsigned CHECK_PARALLELISM = 85,
   parameter int unsigned SHIFT_WIDTH       = 7,
   parameter int unsigned LAYER_NUM         = 4,
   parameter int unsigned ROW_WEIGHT        = 6,
   parameter int unsigned ITER_WIDTH        = 5,
   parameter int unsigned ADDR_WIDTH        = 5,
   localparam int unsigned LAYER_W = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
   input  logic                   sys_clk,
   input  logic                   rstn,
   input  logic                   cfg_we,
   input  logic [ADDR_WIDTH-1:0]  cfg_addr,
   input  logic [SHIFT_WIDTH-1:0] cfg_shift,
   input  logic                   start,
   input  logic [ITER_WIDTH-1:0]  iter_max,
   input  logic                   shift_ready,
   output logic [SHIFT_WIDTH-1:0] shift_factor,
   output logic                   shift_valid,
   output logic                   sched_cmd,
   output logic [LAYER_W-1:0]     layer_idx,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err
);

   localparam int unsigned DEPTH = LAYER_NUM * ROW_WEIGHT;
   localparam int unsigned COL_W = (ROW_WEIGHT > 1) ? $clog2(ROW_WEIGHT) : 1;
   localparam logic [ADDR_WIDTH:0]  DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [SHIFT_WIDTH:0] P_L     = (SHIFT_WIDTH + 1)'(CHECK_PARALLELISM);

   typedef enum logic [1:0] {StIdle, StVn, StCn, StDone} state_e;

   state_e                 state_q, state_d;
   logic [ITER_WIDTH-1:0]  iter_q, iter_d, iter_last_q, iter_last_d;
   logic [LAYER_W-1:0]     layer_q, layer_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [SHIFT_WIDTH-1:0] tbl_q [DEPTH];

   logic [SHIFT_WIDTH-1:0] factor_d;
   logic                   valid_d, cmd_d, busy_d, done_d;
   logic [LAYER_W-1:0]     lidx_d;

   logic                   accept, last_col, load, tbl_we, addr_ok;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [SHIFT_WIDTH-1:0] rd_shift;
   logic [SHIFT_WIDTH:0]   rev_wide;

   assign accept   = shift_valid & shift_ready;
   assign last_col = (col_q == COL_W'(ROW_WEIGHT - 1));
   assign addr_ok  = ({1'b0, cfg_addr} < DEPTH_L);

`ifdef QSN_SEQ_CFG_CHECK_EN
   logic shift_bad, cfg_err_q;
   assign shift_bad = ({1'b0, cfg_shift} >= P_L);
   assign tbl_we    = cfg_we && (state_q == StIdle) && addr_ok && !shift_bad;

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         cfg_err_q <= 1'b0;
      end else if (cfg_we && (state_q == StIdle) && addr_ok && shift_bad) begin
         cfg_err_q <= 1'b1;
      end
   end
   assign cfg_err = cfg_err_q;
`else
   assign tbl_we  = cfg_we && (state_q == StIdle) && addr_ok;
   assign cfg_err = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      end else if (tbl_we) begin
         tbl_q[cfg_addr] <= cfg_shift;
      end
   end

   // Walk pointer (state, iter, layer, col) always names the beat on the output, or the
   // next one to present while shift_valid is low.
   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      iter_last_d = iter_last_q;
      layer_d     = layer_q;
      col_d       = col_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               iter_last_d = (iter_max == '0) ? '0 : iter_max - 1'b1;
               iter_d      = '0;
               layer_d     = '0;
               col_d       = '0;
               state_d     = StVn;
            end
         end
         StVn: begin
            if (accept) begin
               if (last_col) begin
                  col_d   = '0;
                  state_d = StCn;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StCn: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  if (layer_q != LAYER_W'(LAYER_NUM - 1)) begin
                     layer_d = layer_q + 1'b1;
                     state_d = StVn;
                  end else if (iter_q != iter_last_q) begin
                     layer_d = '0;
                     iter_d  = iter_q + 1'b1;
                     state_d = StVn;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output beat is fetched from the next pointer so acceptance reloads with no bubble.
   assign rd_addr  = ADDR_WIDTH'(int'(layer_d) * ROW_WEIGHT + int'(col_d));
   assign rd_shift = tbl_q[rd_addr];
   assign rev_wide = P_L - {1'b0, rd_shift};

   // Entering from IDLE skips a cycle so the first beat lands one edge after start.
   assign load = ((state_q == StVn) || (state_q == StCn)) &&
                 ((state_d == StVn) || (state_d == StCn)) && (!shift_valid || accept);

   always_comb begin
      factor_d = shift_factor;
      valid_d  = shift_valid;
      cmd_d    = sched_cmd;
      lidx_d   = layer_idx;
      if (load) begin
         valid_d = 1'b1;
         cmd_d   = (state_d == StCn);
         lidx_d  = layer_d;
         if (state_d == StCn) begin
            factor_d = (rd_shift == '0) ? '0 : rev_wide[SHIFT_WIDTH-1:0];
         end else begin
            factor_d = rd_shift;
         end
      end else if ((state_d != StVn) && (state_d != StCn)) begin
         valid_d = 1'b0;
      end
   end

   // busy lags the state register by one cycle on entry and drops as DONE exits.
   assign busy_d = (state_q != StIdle) && (state_d != StIdle);

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         iter_q       <= '0;
         iter_last_q  <= '0;
         layer_q      <= '0;
         col_q        <= '0;
         shift_factor <= '0;
         shift_valid  <= 1'b0;
         sched_cmd    <= 1'b0;
         layer_idx    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         iter_q       <= iter_d;
         iter_last_q  <= iter_last_d;
         layer_q      <= layer_d;
         col_q        <= col_d;
         shift_factor <= factor_d;
         shift_valid  <= valid_d;
         sched_cmd    <= cmd_d;
         layer_idx    <= lidx_d;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_qsn_shift_sequencer.sv
module tb_qsn_shift_sequencer;

   localparam int P     = 85;
   localparam int LN    = 4;
   localparam int RW    = 6;
   localparam int DEPTH = LN * RW;
`ifdef QSN_SEQ_CFG_CHECK_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic       sys_clk = 1'b0;
   logic       rstn = 1'b0;
   logic       cfg_we = 1'b0;
   logic [4:0] cfg_addr = '0;
   logic [6:0] cfg_shift = '0;
   logic       start = 1'b0;
   logic [4:0] iter_max = '0;
   logic       shift_ready = 1'b0;
   logic [6:0] shift_factor;
   logic       shift_valid, sched_cmd, busy, done, cfg_err;
   logic [1:0] layer_idx;

   qsn_shift_sequencer dut (
      .sys_clk      (sys_clk),
      .rstn         (rstn),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_shift    (cfg_shift),
      .start        (start),
      .iter_max     (iter_max),
      .shift_ready  (shift_ready),
      .shift_factor (shift_factor),
      .shift_valid  (shift_valid),
      .sched_cmd    (sched_cmd),
      .layer_idx    (layer_idx),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {int f; int cmd; int layer;} beat_t;
   typedef struct {int f; int cmd;} vec_t;
   typedef struct {int addr; int val; int exp_err;} cfgv_t;

   int    checks = 0;
   int    errors = 0;
   int    tbl_m[DEPTH];
   beat_t got_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int rev_shift(input int s);
      return (s == 0) ? 0 : (P - s) % P;
   endfunction

   // Table write as seen by the model: address filter plus optional range check.
   task automatic cfg_write(input int a, input int v);
      cfg_we = 1'b1;
      cfg_addr = a[4:0];
      cfg_shift = v[6:0];
      @(posedge sys_clk); #1;
      cfg_we = 1'b0;
      if (a < DEPTH && !(CHK == 1 && v >= P)) tbl_m[a] = v;
   endtask

   // mode: 0 ready high, 1 three-cycle stall in layer 2, 2 random ready, 3 ready high
   // with start/cfg_we pulsed mid-run.
   task automatic run_check(input string name, input int im, input int mode);
      beat_t exp_q[$];
      int iters, c, first_bad, stab_bad, done_cnt, done_c, last_acc, stall_left;
      logic pv, pr, pc, stalled;
      logic [6:0] pf;
      logic [1:0] pl;
      iters = (im == 0) ? 1 : im;
      for (int it = 0; it < iters; it++)
         for (int l = 0; l < LN; l++) begin
            for (int k = 0; k < RW; k++) exp_q.push_back('{tbl_m[l*RW+k], 0, l});
            for (int k = 0; k < RW; k++) exp_q.push_back('{rev_shift(tbl_m[l*RW+k]), 1, l});
         end
      got_q.delete();
      c = 0; first_bad = -1; stab_bad = 0; done_cnt = 0; done_c = -1; last_acc = -1;
      stall_left = 0; pv = 0; pr = 0; pc = 0; pf = '0; pl = '0; stalled = 0;
      cfg_addr = 5'd0;
      cfg_shift = 7'd33;
      start = 1'b1;
      iter_max = im[4:0];
      @(posedge sys_clk); #1;
      start = 1'b0;
      while (c < 3000) begin
         if (c == 0) check({name, " valid_low_after_start_edge"}, int'(shift_valid), 0);
         if (c == 1) begin
            check({name, " valid_first_beat"}, int'(shift_valid), 1);
            check({name, " busy_first_beat"}, int'(busy), 1);
         end
         if (pv && !pr && (!shift_valid || shift_factor != pf || sched_cmd != pc ||
                           layer_idx != pl)) stab_bad++;
         if (done) begin
            done_cnt++;
            if (done_c < 0) begin
               done_c = c;
               check({name, " busy_with_done"}, int'(busy), 1);
            end
         end
         if (done_c >= 0 && c == done_c + 1) begin
            check({name, " busy_low_after_done"}, int'(busy), 0);
            break;
         end
         start = (mode == 3 && c == 10);
         cfg_we = (mode == 3 && c == 10);
         if (mode == 1 && !stalled && got_q.size() == 2 * 2 * RW + 4) begin
            stall_left = 3;
            stalled = 1;
         end
         if (mode == 2) shift_ready = ($urandom_range(0, 3) != 0);
         else if (stall_left > 0) begin
            shift_ready = 1'b0;
            stall_left--;
         end else shift_ready = 1'b1;
         if (shift_valid && shift_ready) begin
            got_q.push_back('{int'(shift_factor), int'(sched_cmd), int'(layer_idx)});
            last_acc = c;
         end
         pv = shift_valid; pr = shift_ready; pf = shift_factor; pc = sched_cmd; pl = layer_idx;
         @(posedge sys_clk); #1;
         c++;
      end
      start = 1'b0;
      cfg_we = 1'b0;
      shift_ready = 1'b0;
      check({name, " done_seen_in_budget"}, int'(done_c >= 0), 1);
      check({name, " beat_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (first_bad < 0 && (got_q[i].f != exp_q[i].f || got_q[i].cmd != exp_q[i].cmd ||
                               got_q[i].layer != exp_q[i].layer)) first_bad = i;
      check({name, " first_bad_beat"}, first_bad, -1);
      check({name, " stall_instability"}, stab_bad, 0);
      check({name, " done_pulses"}, done_cnt, 1);
      check({name, " done_after_last_accept"}, done_c, last_acc + 1);
      if (mode == 0 || mode == 3) check({name, " no_bubbles"}, done_c, exp_q.size() + 1);
   endtask

   initial begin
      vec_t  vecs[12];
      cfgv_t cv[3];
      int    n;
      vecs = '{'{5, 0}, '{0, 0}, '{10, 0}, '{10, 0}, '{10, 0}, '{10, 0},
               '{80, 1}, '{0, 1}, '{75, 1}, '{75, 1}, '{75, 1}, '{75, 1}};
      cv = '{'{3, 85, CHK}, '{4, 84, CHK}, '{30, 50, CHK}};
      for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;

      repeat (2) @(posedge sys_clk);
      #1;
      check("rst shift_factor", int'(shift_factor), 0);
      check("rst shift_valid", int'(shift_valid), 0);
      check("rst sched_cmd", int'(sched_cmd), 0);
      check("rst layer_idx", int'(layer_idx), 0);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst cfg_err", int'(cfg_err), 0);
      @(negedge sys_clk) rstn = 1'b1;
      @(posedge sys_clk); #1;

      for (int i = 0; i < DEPTH; i++) cfg_write(i, 10);
      cfg_write(0, 5);
      cfg_write(1, 0);
      cfg_write(30, 50);

      run_check("basic", 1, 0);
      for (int i = 0; i < 12; i++)
         if (i < got_q.size()) begin
            check($sformatf("vec%0d factor", i), got_q[i].f, vecs[i].f);
            check($sformatf("vec%0d cmd", i), got_q[i].cmd, vecs[i].cmd);
         end

      run_check("stall_l2", 1, 1);
      run_check("iter0", 0, 0);
      run_check("iter3", 3, 0);
      run_check("disturb", 1, 3);
      run_check("after_disturb", 1, 0);
      check("after_disturb entry0", got_q.size() > 0 ? got_q[0].f : -1, 5);

      for (int i = 0; i < 3; i++) begin
         cfg_write(cv[i].addr, cv[i].val);
         check($sformatf("cfgvec%0d cfg_err", i), int'(cfg_err), cv[i].exp_err);
      end
      run_check("cfg_range", 1, 0);
      check("cfg_range entry3", got_q.size() > 3 ? got_q[3].f : -1, CHK ? 10 : 85);

      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < DEPTH; i++) cfg_write(i, $urandom_range(0, P - 1));
         run_check($sformatf("rand%0d", r), $urandom_range(1, 3), 2);
      end

      // Reset in the middle of a run.
      shift_ready = 1'b1;
      start = 1'b1;
      iter_max = 5'd1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 200 && n < 20; c++) begin
         if (shift_valid && shift_ready) n++;
         if (n < 20) begin
            @(posedge sys_clk); #1;
         end
      end
      check("midrst reached beat 20", n, 20);
      #2 rstn = 1'b0;
      #1;
      check("midrst shift_factor", int'(shift_factor), 0);
      check("midrst shift_valid", int'(shift_valid), 0);
      check("midrst sched_cmd", int'(sched_cmd), 0);
      check("midrst layer_idx", int'(layer_idx), 0);
      check("midrst busy", int'(busy), 0);
      check("midrst done", int'(done), 0);
      check("midrst cfg_err", int'(cfg_err), 0);
      shift_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;
      @(negedge sys_clk) rstn = 1'b1;
      @(posedge sys_clk); #1;
      run_check("post_reset_zero", 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
